rgb_ctrl_sequencer: RTL and testbench

- Front-panel controller for the RGB pixel processing stage.
- Debounces three pushbuttons and sequences the contrast level (2-bit control pair), brightness enable and per-channel enables.
- Selections collect in shadow registers. They are committed to the datapath only at a frame boundary, so a setting never changes mid-frame.
- Optional demo mode steps the contrast level automatically every N frames.
- Sits between KEY inputs / VGA timing and the pixel processor's control inputs.

---
 rtl/rgb_ctrl_sequencer_if.sv | 26 ++
 rtl/rgb_ctrl_sequencer.sv | 141 ++++++++++++++
 tb/tb_rgb_ctrl_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_ctrl_sequencer_if.sv
// Front-panel bundle: raw panel/timing inputs toward the sequencer and the
// committed control outputs toward the pixel processor.
interface rgb_ctrl_sequencer_if;
   logic       key_level_n;
   logic       key_bright_n;
   logic       key_chan_n;
   logic       demo_en;
   logic       vsync_n;
   logic [1:0] ctrl_level;
   logic       bright_en;
   logic       r_en;
   logic       g_en;
   logic       b_en;
   logic       update_pulse;
   logic       pending;

   modport master (
      output key_level_n, key_bright_n, key_chan_n, demo_en, vsync_n,
      input  ctrl_level, bright_en, r_en, g_en, b_en, update_pulse, pending
   );

   modport slave (
      input  key_level_n, key_bright_n, key_chan_n, demo_en, vsync_n,
      output ctrl_level, bright_en, r_en, g_en, b_en, update_pulse, pending
   );
endinterface

// File: rtl/rgb_ctrl_sequencer.sv
// Debounces three panel keys into shadow settings and commits them to the
// pixel-processor controls only at a frame start; optional demo auto-stepping.
module rgb_ctrl_sequencer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DEMO_FRAMES     = 60
) (
   input logic                 clk,
   input logic                 reset_n,
   rgb_ctrl_sequencer_if.slave bus
);
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int FR_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(DEMO_FRAMES - 1);

   // Bit map: 0 level key, 1 bright key, 2 chan key, 3 demo_en, 4 vsync_n
   logic [4:0] raw;
   logic [4:0] sync1_reg, sync2_reg;
   logic [2:0] press;

   assign raw = {bus.vsync_n, bus.demo_en, bus.key_chan_n, bus.key_bright_n, bus.key_level_n};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
         logic [DB_W-1:0] cnt_reg;
         logic            stable_reg;
         logic            press_reg;

         // A stable flip that starts from 1 is by definition a press.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b1;
               press_reg  <= 1'b0;
            end else begin
               press_reg <= 1'b0;
               if (sync2_reg[gi] == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  cnt_reg    <= '0;
                  stable_reg <= sync2_reg[gi];
                  press_reg  <= stable_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   logic            vsync_prev_reg;
   logic            frame_start;
   logic            demo_s;
   logic [FR_W-1:0] frame_cnt_reg;
   logic            demo_step;

   assign demo_s      = sync2_reg[3];
   assign frame_start = vsync_prev_reg & ~sync2_reg[4];
   assign demo_step   = demo_s & frame_start & (frame_cnt_reg == FR_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_prev_reg <= 1'b1;
         frame_cnt_reg  <= '0;
      end else begin
         vsync_prev_reg <= sync2_reg[4];
         if (!demo_s)
            frame_cnt_reg <= '0;
         else if (frame_start)
            frame_cnt_reg <= (frame_cnt_reg == FR_LAST) ? '0 : frame_cnt_reg + 1'b1;
      end
   end

   logic [1:0] level_sh_reg, level_sh_next, level_reg;
   logic       bright_sh_reg, bright_sh_next, bright_reg;
   logic [2:0] mask_sh_reg, mask_sh_next, mask_reg;
   logic       pending_reg, pending_next;
   logic       update_reg;
   logic       commit;

   always_comb begin
      level_sh_next  = 2'(level_sh_reg + {1'b0, press[0]} + {1'b0, demo_step});
      bright_sh_next = bright_sh_reg ^ press[1];
      mask_sh_next   = mask_sh_reg;
      if (press[2]) begin
         case (mask_sh_reg)
            3'b111:  mask_sh_next = 3'b100;
            3'b100:  mask_sh_next = 3'b010;
            3'b010:  mask_sh_next = 3'b001;
            default: mask_sh_next = 3'b111;
         endcase
      end
      commit       = frame_start & pending_reg;
      // An event landing in a commit cycle keeps the flag set for the next frame.
      pending_next = (|press) | demo_step | (pending_reg & ~commit);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_sh_reg  <= 2'd0;
         bright_sh_reg <= 1'b0;
         mask_sh_reg   <= 3'b111;
         level_reg     <= 2'd0;
         bright_reg    <= 1'b0;
         mask_reg      <= 3'b111;
         pending_reg   <= 1'b0;
         update_reg    <= 1'b0;
      end else begin
         level_sh_reg  <= level_sh_next;
         bright_sh_reg <= bright_sh_next;
         mask_sh_reg   <= mask_sh_next;
         pending_reg   <= pending_next;
         update_reg    <= commit;
         if (commit) begin
            level_reg  <= level_sh_reg;
            bright_reg <= bright_sh_reg;
            mask_reg   <= mask_sh_reg;
         end
      end
   end

   assign bus.ctrl_level   = level_reg;
   assign bus.bright_en    = bright_reg;
   assign bus.r_en         = mask_reg[2];
   assign bus.g_en         = mask_reg[1];
   assign bus.b_en         = mask_reg[0];
   assign bus.update_pulse = update_reg;
   assign bus.pending      = pending_reg;
endmodule

// File: tb/tb_rgb_ctrl_sequencer.sv
// Directed bench: table of press/frame transactions plus hand-timed sequences
// for debounce latency, glitch rejection, commit/event collision and demo mode.
module tb_rgb_ctrl_sequencer;
   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   int   pulse_cnt = 0;
   int   p0;

   rgb_ctrl_sequencer_if bus();

   rgb_ctrl_sequencer #(.DEBOUNCE_CYCLES(4), .DEMO_FRAMES(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.update_pulse === 1'b1) pulse_cnt++;

   typedef struct {
      logic [2:0] mask;    // {chan, bright, level} keys pressed together
      int         reps;
      logic [1:0] lvl;
      logic       br;
      logic [2:0] rgb;
      int         pulses;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0d", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame();
      bus.vsync_n = 1'b0;
      tick(4);
      bus.vsync_n = 1'b1;
      tick(4);
   endtask

   task automatic press(input logic [2:0] m);
      bus.key_level_n  = ~m[0];
      bus.key_bright_n = ~m[1];
      bus.key_chan_n   = ~m[2];
      tick(8);
      bus.key_level_n  = 1'b1;
      bus.key_bright_n = 1'b1;
      bus.key_chan_n   = 1'b1;
      tick(8);
   endtask

   task automatic check_out(input string tag, input logic [1:0] lvl, input logic br,
                            input logic [2:0] rgb);
      check($sformatf("%s.level", tag), {6'd0, bus.ctrl_level}, {6'd0, lvl});
      check($sformatf("%s.bright", tag), {7'd0, bus.bright_en}, {7'd0, br});
      check($sformatf("%s.rgb", tag), {5'd0, bus.r_en, bus.g_en, bus.b_en}, {5'd0, rgb});
   endtask

   initial begin
      logic [1:0] demo_lvl [7];
      demo_lvl = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};

      // State entering the table: level 1, bright 0, rgb 111
      vecs[0] = '{3'b100, 1, 2'd1, 1'b0, 3'b100, 1};
      vecs[1] = '{3'b100, 1, 2'd1, 1'b0, 3'b010, 1};
      vecs[2] = '{3'b100, 1, 2'd1, 1'b0, 3'b001, 1};
      vecs[3] = '{3'b100, 1, 2'd1, 1'b0, 3'b111, 1};
      vecs[4] = '{3'b100, 1, 2'd1, 1'b0, 3'b100, 1};
      vecs[5] = '{3'b001, 3, 2'd0, 1'b0, 3'b100, 1};
      vecs[6] = '{3'b001, 4, 2'd0, 1'b0, 3'b100, 1};
      vecs[7] = '{3'b010, 1, 2'd0, 1'b1, 3'b100, 1};
      vecs[8] = '{3'b111, 1, 2'd1, 1'b0, 3'b010, 1};
      vecs[9] = '{3'b000, 0, 2'd1, 1'b0, 3'b010, 0};

      bus.key_level_n = 1'b1; bus.key_bright_n = 1'b1; bus.key_chan_n = 1'b1;
      bus.demo_en = 1'b0; bus.vsync_n = 1'b1;
      reset_n = 1'b0;
      tick(3);
      check_out("reset", 2'd0, 1'b0, 3'b111);
      check("reset.pending", {7'd0, bus.pending}, 8'd0);
      check("reset.update", {7'd0, bus.update_pulse}, 8'd0);
      reset_n = 1'b1;
      tick(2);

      // Idle frames: nothing pending, nothing committed
      repeat (3) frame();
      check_out("idle", 2'd0, 1'b0, 3'b111);
      check("idle.pulses", 8'(pulse_cnt), 8'd0);
      check("idle.pending", {7'd0, bus.pending}, 8'd0);

      // Pending rises exactly 2 + 4 + 1 cycles after the raw edge
      bus.key_level_n = 1'b0;
      tick(6);
      check("lat.pending_early", {7'd0, bus.pending}, 8'd0);
      tick(1);
      check("lat.pending_on_time", {7'd0, bus.pending}, 8'd1);
      tick(3);
      bus.key_level_n = 1'b1;
      tick(8);
      check("lat.level_before_frame", {6'd0, bus.ctrl_level}, 8'd0);
      p0 = pulse_cnt;
      frame();
      check("lat.level", {6'd0, bus.ctrl_level}, 8'd1);
      check("lat.pulses", 8'(pulse_cnt - p0), 8'd1);
      check("lat.pending_clear", {7'd0, bus.pending}, 8'd0);

      // Glitch of 3 synced cycles never reaches the debounce terminal count
      bus.key_bright_n = 1'b0;
      tick(3);
      bus.key_bright_n = 1'b1;
      tick(10);
      check("glitch.pending", {7'd0, bus.pending}, 8'd0);
      p0 = pulse_cnt;
      frame();
      check("glitch.bright", {7'd0, bus.bright_en}, 8'd0);
      check("glitch.pulses", 8'(pulse_cnt - p0), 8'd0);

      for (int i = 0; i < 10; i++) begin
         p0 = pulse_cnt;
         for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].mask);
         check($sformatf("vec%0d.pending_pre", i), {7'd0, bus.pending},
               (vecs[i].reps > 0) ? 8'd1 : 8'd0);
         frame();
         check_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].br, vecs[i].rgb);
         check($sformatf("vec%0d.pulses", i), 8'(pulse_cnt - p0), 8'(vecs[i].pulses));
         check($sformatf("vec%0d.pending_post", i), {7'd0, bus.pending}, 8'd0);
      end

      // Level press event lands in the same cycle as the frame-start commit
      press(3'b010);
      p0 = pulse_cnt;
      bus.key_level_n = 1'b0;
      tick(4);
      bus.vsync_n = 1'b0;
      tick(4);
      check_out("collide", 2'd1, 1'b1, 3'b010);
      check("collide.pulses", 8'(pulse_cnt - p0), 8'd1);
      check("collide.pending", {7'd0, bus.pending}, 8'd1);
      bus.vsync_n = 1'b1;
      bus.key_level_n = 1'b1;
      tick(10);
      frame();
      check_out("collide_next", 2'd2, 1'b1, 3'b010);
      check("collide_next.pulses", 8'(pulse_cnt - p0), 8'd2);
      check("collide_next.pending", {7'd0, bus.pending}, 8'd0);

      // Demo mode from a fresh reset
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      bus.demo_en = 1'b1;
      tick(4);
      p0 = pulse_cnt;
      for (int f = 0; f < 7; f++) begin
         frame();
         check($sformatf("demo.f%0d.level", f + 1), {6'd0, bus.ctrl_level}, {6'd0, demo_lvl[f]});
      end
      check("demo.pulses", 8'(pulse_cnt - p0), 8'd2);
      bus.demo_en = 1'b0;
      tick(4);
      repeat (3) frame();
      check("demo_off.level", {6'd0, bus.ctrl_level}, 8'd2);
      check("demo_off.pending", {7'd0, bus.pending}, 8'd0);
      bus.demo_en = 1'b1;
      tick(4);
      repeat (2) frame();
      check("demo_re.pending_f2", {7'd0, bus.pending}, 8'd0);
      frame();
      check("demo_re.pending_f3", {7'd0, bus.pending}, 8'd1);
      check("demo_re.level_f3", {6'd0, bus.ctrl_level}, 8'd2);

      // Asynchronous reset mid-debounce and mid-demo
      bus.key_level_n = 1'b0;
      tick(3);
      reset_n = 1'b0;
      #1;
      check_out("areset", 2'd0, 1'b0, 3'b111);
      check("areset.pending", {7'd0, bus.pending}, 8'd0);
      check("areset.update", {7'd0, bus.update_pulse}, 8'd0);
      bus.key_level_n = 1'b1;
      bus.demo_en = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      p0 = pulse_cnt;
      frame();
      check("post_reset.level", {6'd0, bus.ctrl_level}, 8'd0);
      check("post_reset.pulses", 8'(pulse_cnt - p0), 8'd0);
      check("post_reset.pending", {7'd0, bus.pending}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
